// File: rtl/arbiter_rr_burst_if.sv
// Client/SDRAM-controller bundle around arbiter_rr_burst.
// The slave modport is the arbiter's view. The master modport is the environment: clients plus the controller.
interface arbiter_rr_burst_if #(
  parameter int N   = 4,
  parameter int IDN = 2,
  parameter int AN  = 24,
  parameter int DN  = 16
);
  logic [N-1:0]    req;
  logic [N-1:0]    wr;
  logic [N*AN-1:0] addr;
  logic [N*DN-1:0] wdata;
  logic [N-1:0]    ack;
  logic [N-1:0]    rvalid;
  logic [DN-1:0]   rdata;
  logic            mem_req;
  logic            mem_wr;
  logic [AN-1:0]   mem_addr;
  logic [DN-1:0]   mem_data;
  logic [IDN-1:0]  mem_id;
  logic            mem_ack;
  logic            mem_valid;
  logic [DN-1:0]   mem_rdata;
  logic [IDN-1:0]  mem_rid;
  logic            busy;

  modport slave (
    input  req, wr, addr, wdata, mem_ack, mem_valid, mem_rdata, mem_rid,
    output ack, rvalid, rdata, mem_req, mem_wr, mem_addr, mem_data, mem_id, busy
  );

  modport master (
    output req, wr, addr, wdata, mem_ack, mem_valid, mem_rdata, mem_rid,
    input  ack, rvalid, rdata, mem_req, mem_wr, mem_addr, mem_data, mem_id, busy
  );
endinterface

// File: rtl/arbiter_rr_burst.sv
// Round-robin, burst-locking arbiter in front of the single SDRAM request port.
// Tagged read returns are steered back to the client that issued them.
module arbiter_rr_burst #(
  parameter int N     = 4,
  parameter int IDN   = 2,
  parameter int AN    = 24,
  parameter int DN    = 16,
  parameter int BURST = 8
) (
  input  logic                clkSYS,
  input  logic                n_reset,
  arbiter_rr_burst_if.slave   bus
);
  localparam int CN = $clog2(BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDN-1:0] g;
  logic [IDN-1:0] last;
  logic [CN-1:0]  cnt;
  logic [IDN-1:0] nxt_g;
  logic [IDN-1:0] idx;
  logic           nxt_found;
  logic           granted;
  logic           cur_req;
  logic           accept;
  logic           rel;

  // Scan last+1, last+2, ... (mod N). The first requester found wins.
  always_comb begin
    nxt_g     = '0;
    nxt_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDN'((32'(last) + k) % N);
      if (!nxt_found && bus.req[idx]) begin
        nxt_g     = idx;
        nxt_found = 1'b1;
      end
    end
  end

  assign granted = (state == GRANT);
  assign cur_req = bus.req[g];
  assign accept  = granted & cur_req & bus.mem_ack;
  assign rel     = granted & (~cur_req | (accept & (cnt == CN'(BURST - 1))));

  assign bus.busy     = granted;
  assign bus.mem_req  = granted & cur_req;
  assign bus.mem_wr   = bus.wr[g];
  assign bus.mem_addr = bus.addr[g*AN +: AN];
  assign bus.mem_data = bus.wdata[g*DN +: DN];
  assign bus.mem_id   = g;

  always_comb begin
    bus.ack = '0;
    if (accept) bus.ack[g] = 1'b1;
  end

  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
      g     <= '0;
      last  <= IDN'(N - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            g     <= nxt_g;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept) cnt <= cnt + 1'b1;
          if (rel) begin
            last  <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The read return is independent of the grant. A tag outside 0..N-1 raises no rvalid.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= '0;
      if (bus.mem_valid) begin
        if (32'(bus.mem_rid) < N) bus.rvalid[bus.mem_rid] <= 1'b1;
        bus.rdata <= bus.mem_rdata;
      end
    end
  end
endmodule
